// File: rtl/mipi_dsi_pattern_gen_if.sv
// Pixel request/response bundle between the DSI packetiser and a pixel source.
// The packetiser (master) issues one request per cycle; the source answers one cycle later.
interface mipi_dsi_pattern_gen_if #(
  parameter int COMP_W = 8,
  parameter int POS_W  = 11
);
  logic                  rgb_data_req;
  logic [POS_W-1:0]      pixel_xpos;
  logic [POS_W-1:0]      pixel_ypos;
  logic [3*COMP_W-1:0]   pixel_data;
  logic                  pixel_valid;

  modport master (
    output rgb_data_req, pixel_xpos, pixel_ypos,
    input  pixel_data, pixel_valid
  );

  modport slave (
    input  rgb_data_req, pixel_xpos, pixel_ypos,
    output pixel_data, pixel_valid
  );
endinterface

// File: rtl/mipi_dsi_pattern_gen.sv
// Multi-mode test-pattern source for the DSI HS packetiser.
// Modes: 0 colour bars, 1 horizontal ramp, 2 vertical ramp, 3 checker
// (inverting on odd frames), 4 solid colour, 5 scrolling vertical bar.
// Mode and solid colour are latched at frame start so a frame is never torn.
// Assumes COMP_W <= POS_W and CHECK_LOG2 < POS_W.
module mipi_dsi_pattern_gen #(
  parameter int COMP_W     = 8,
  parameter int POS_W      = 11,
  parameter int CHECK_LOG2 = 5,
  parameter int FCNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mipi_dsi_pattern_gen_if.slave pix,
  input  logic [2:0]           pattern_sel_i,
  input  logic [3*COMP_W-1:0]  solid_rgb_i,
  input  logic [POS_W-1:0]     scroll_step_i,
  input  logic [POS_W-1:0]     h_disp_i,
  input  logic [POS_W-1:0]     v_disp_i,
  output logic [FCNT_W-1:0]    frame_cnt_o,
  output logic [2:0]           mode_active_o
);

  localparam int PIX_W = 3 * COMP_W;
  localparam logic [PIX_W-1:0]  WHITE   = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0]  BLACK   = '0;
  localparam logic [POS_W-1:0]  POS_ONE = 1;
  localparam logic [FCNT_W-1:0] FC_ONE  = 1;
  localparam logic [POS_W:0]    BAR_LEN = (POS_W+1)'(2**CHECK_LOG2);

  localparam logic [2:0] M_COLORBAR = 3'd0;
  localparam logic [2:0] M_HGRAD    = 3'd1;
  localparam logic [2:0] M_VGRAD    = 3'd2;
  localparam logic [2:0] M_CHECKER  = 3'd3;
  localparam logic [2:0] M_SOLID    = 3'd4;
  localparam logic [2:0] M_MOVBAR   = 3'd5;

  // Unsupported selector codes fall back to colour bars.
  function automatic logic [2:0] remap(input logic [2:0] sel);
    return (sel > 3'd5) ? M_COLORBAR : sel;
  endfunction

  // SMPTE-like bar order; each channel is either full scale or zero.
  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111; // white
      3'd1:    rgb = 3'b110; // yellow
      3'd2:    rgb = 3'b011; // cyan
      3'd3:    rgb = 3'b010; // green
      3'd4:    rgb = 3'b101; // magenta
      3'd5:    rgb = 3'b100; // red
      3'd6:    rgb = 3'b001; // blue
      default: rgb = 3'b000; // black
    endcase
    return {{COMP_W{rgb[2]}}, {COMP_W{rgb[1]}}, {COMP_W{rgb[0]}}};
  endfunction

  // State
  logic [PIX_W-1:0]  data_q,   data_d;
  logic              valid_q;
  logic [FCNT_W-1:0] fcnt_q,   fcnt_d;
  logic [2:0]        mode_q,   mode_d;
  logic [PIX_W-1:0]  solid_q,  solid_d;
  logic [POS_W-1:0]  scroll_q, scroll_d;
  logic [POS_W-1:0]  col_q,    col_d;
  logic [2:0]        bar_q,    bar_d;

  // Request decode
  logic             req;
  logic [POS_W-1:0] xpos, ypos;
  logic             in_range, fs, line_start;

  assign req        = pix.rgb_data_req;
  assign xpos       = pix.pixel_xpos;
  assign ypos       = pix.pixel_ypos;
  assign in_range   = (xpos < h_disp_i) && (ypos < v_disp_i);
  assign line_start = (xpos == '0);
  assign fs         = req && in_range && line_start && (ypos == '0);

  // Frame-start pixel already sees the new mode and colour
  logic [2:0]       mode_eff;
  logic [PIX_W-1:0] solid_eff;

  assign mode_eff  = fs ? remap(pattern_sel_i) : mode_q;
  assign solid_eff = fs ? solid_rgb_i : solid_q;

  // Colour-bar tracking: the register pair describes the position of the next
  // pixel in the line; a column-0 request restarts it regardless of history.
  logic [POS_W-1:0] bar_w, cur_col;
  logic [2:0]       cur_bar;
  logic             bar_end;

  assign bar_w   = h_disp_i >> 3;
  assign cur_col = line_start ? '0 : col_q;
  assign cur_bar = line_start ? 3'd0 : bar_q;
  // bar_w==0 never matches, so the whole line stays in bar 0 (white).
  assign bar_end = (bar_w != '0) && (cur_col == (bar_w - POS_ONE)) && (cur_bar != 3'd7);

  // Advance the bar counters on every in-range request; hold otherwise
  always_comb begin
    col_d = col_q;
    bar_d = bar_q;
    if (req && in_range) begin
      if (bar_end) begin
        col_d = '0;
        bar_d = 3'(cur_bar + 3'd1);
      end else begin
        col_d = cur_col + POS_ONE;
        bar_d = cur_bar;
      end
    end
  end

  // Scroll advance with a single conditional wrap against the line width
  logic [POS_W:0] scroll_sum;

  assign scroll_sum = {1'b0, scroll_q} + {1'b0, scroll_step_i};

  // Per-frame registers: only touched on frame start
  always_comb begin
    fcnt_d   = fcnt_q;
    mode_d   = mode_q;
    solid_d  = solid_q;
    scroll_d = scroll_q;
    if (fs) begin
      fcnt_d   = fcnt_q + FC_ONE;
      mode_d   = remap(pattern_sel_i);
      solid_d  = solid_rgb_i;
      scroll_d = POS_W'((scroll_sum >= {1'b0, h_disp_i}) ?
                        (scroll_sum - {1'b0, h_disp_i}) : scroll_sum);
    end
  end

  // Pattern evaluation for the current request (moving bar uses the old scroll)
  logic [POS_W:0] x_ext, bar_lo, bar_hi;
  logic           chk_white, mov_white;

  assign x_ext     = {1'b0, xpos};
  assign bar_lo    = {1'b0, scroll_q};
  assign bar_hi    = bar_lo + BAR_LEN;
  assign mov_white = (x_ext >= bar_lo) && (x_ext < bar_hi);
  assign chk_white = xpos[CHECK_LOG2] ^ ypos[CHECK_LOG2] ^ fcnt_q[0];

  // Pixel mux; out-of-range requests always answer black
  always_comb begin
    data_d = data_q;
    if (req) begin
      case (mode_eff)
        M_COLORBAR: data_d = bar_color(cur_bar);
        M_HGRAD:    data_d = {3{xpos[COMP_W-1:0]}};
        M_VGRAD:    data_d = {3{ypos[COMP_W-1:0]}};
        M_CHECKER:  data_d = chk_white ? WHITE : BLACK;
        M_SOLID:    data_d = solid_eff;
        M_MOVBAR:   data_d = mov_white ? WHITE : BLACK;
        default:    data_d = BLACK;
      endcase
      if (!in_range) data_d = BLACK;
    end
  end

  // Response register: one-cycle latency, data holds when no request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= req;
    end
  end

  // Frame-level and line-level state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt_q   <= '0;
      mode_q   <= M_COLORBAR;
      solid_q  <= '0;
      scroll_q <= '0;
      col_q    <= '0;
      bar_q    <= 3'd0;
    end else begin
      fcnt_q   <= fcnt_d;
      mode_q   <= mode_d;
      solid_q  <= solid_d;
      scroll_q <= scroll_d;
      col_q    <= col_d;
      bar_q    <= bar_d;
    end
  end

  assign pix.pixel_data  = data_q;
  assign pix.pixel_valid = valid_q;
  assign frame_cnt_o     = fcnt_q;
  assign mode_active_o   = mode_q;

endmodule

// File: tb/tb_mipi_dsi_pattern_gen.sv
// Directed bench for the DSI test-pattern source.
module tb_mipi_dsi_pattern_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [10:0] scroll_step, h_disp, v_disp;
  logic [15:0] frame_cnt;
  logic [2:0]  mode_active;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_fc = 16'd0;
  logic [23:0] d;

  mipi_dsi_pattern_gen_if #(.COMP_W(8), .POS_W(11)) pif ();

  mipi_dsi_pattern_gen #(.COMP_W(8), .POS_W(11), .CHECK_LOG2(5), .FCNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .pix           (pif.slave),
    .pattern_sel_i (pattern_sel),
    .solid_rgb_i   (solid_rgb),
    .scroll_step_i (scroll_step),
    .h_disp_i      (h_disp),
    .v_disp_i      (v_disp),
    .frame_cnt_o   (frame_cnt),
    .mode_active_o (mode_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; response sampled just after the following edge
  task automatic px(input int x, input int y, output logic [23:0] dat);
    @(negedge clk);
    pif.rgb_data_req = 1'b1;
    pif.pixel_xpos   = 11'(x);
    pif.pixel_ypos   = 11'(y);
    @(posedge clk);
    #1;
    chk("valid", {31'd0, pif.pixel_valid}, 32'd1);
    dat = pif.pixel_data;
    if (x == 0 && y == 0) exp_fc++;
  endtask

  task automatic fs_fast();
    @(negedge clk);
    pif.rgb_data_req = 1'b1;
    pif.pixel_xpos   = 11'd0;
    pif.pixel_ypos   = 11'd0;
    @(posedge clk);
    exp_fc++;
  endtask

  initial begin
    pif.rgb_data_req = 1'b0;
    pif.pixel_xpos   = '0;
    pif.pixel_ypos   = '0;
    pattern_sel = 3'd0;
    solid_rgb   = 24'h0;
    scroll_step = 11'd0;
    h_disp      = 11'd720;
    v_disp      = 11'd480;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, pif.pixel_valid}, 32'd0);
    chk("rst_data",  {8'd0, pif.pixel_data}, 32'd0);
    chk("rst_fcnt",  {16'd0, frame_cnt}, 32'd0);
    chk("rst_mode",  {29'd0, mode_active}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Colour bars, 720 wide: bar width 90
    for (int x = 0; x < 720; x++) begin
      px(x, 0, d);
      case (x)
        0:   chk("cb_x0",   {8'd0, d}, 32'hFFFFFF);
        89:  chk("cb_x89",  {8'd0, d}, 32'hFFFFFF);
        90:  chk("cb_x90",  {8'd0, d}, 32'hFFFF00);
        629: chk("cb_x629", {8'd0, d}, 32'h0000FF);
        630: chk("cb_x630", {8'd0, d}, 32'h000000);
        719: chk("cb_x719", {8'd0, d}, 32'h000000);
        default: ;
      endcase
    end
    chk("cb_fcnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
    chk("cb_mode", {29'd0, mode_active}, 32'd0);

    // 725 wide: remainder pixels stay in the last bar
    h_disp = 11'd725;
    for (int x = 0; x < 725; x++) begin
      px(x, 1, d);
      case (x)
        629: chk("cb725_x629", {8'd0, d}, 32'h0000FF);
        630: chk("cb725_x630", {8'd0, d}, 32'h000000);
        720: chk("cb725_x720", {8'd0, d}, 32'h000000);
        724: chk("cb725_x724", {8'd0, d}, 32'h000000);
        default: ;
      endcase
    end
    h_disp = 11'd720;

    // Out of range and request gaps
    px(800, 1, d);  chk("oor_x", {8'd0, d}, 32'h000000);
    px(5, 700, d);  chk("oor_y", {8'd0, d}, 32'h000000);
    px(0, 2, d);    chk("line2_x0", {8'd0, d}, 32'hFFFFFF);
    @(negedge clk);
    pif.rgb_data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("gap_valid", {31'd0, pif.pixel_valid}, 32'd0);
      chk("gap_hold",  {8'd0, pif.pixel_data}, 32'hFFFFFF);
    end

    // Mode switch takes effect only at frame start
    pattern_sel = 3'd4;
    solid_rgb   = 24'h123456;
    px(0, 100, d);  chk("sw_pre0", {8'd0, d}, 32'hFFFFFF);
    px(1, 100, d);  chk("sw_pre1", {8'd0, d}, 32'hFFFFFF);
    chk("sw_pre_mode", {29'd0, mode_active}, 32'd0);
    px(0, 0, d);    chk("sw_fs", {8'd0, d}, 32'h123456);
    chk("sw_mode", {29'd0, mode_active}, 32'd4);
    chk("sw_fcnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
    solid_rgb   = 24'hABCDEF;
    pattern_sel = 3'd1;
    px(5, 0, d);    chk("sw_mid", {8'd0, d}, 32'h123456);

    // Checker, odd then even frame
    pattern_sel = 3'd3;
    px(0, 0, d);                            // frame 3
    px(32, 0, d);   chk("chk_odd_a", {8'd0, d}, 32'h000000);
    px(32, 32, d);  chk("chk_odd_b", {8'd0, d}, 32'hFFFFFF);
    px(0, 0, d);                            // frame 4
    px(32, 0, d);   chk("chk_even_a", {8'd0, d}, 32'hFFFFFF);
    px(64, 32, d);  chk("chk_even_b", {8'd0, d}, 32'hFFFFFF);
    px(32, 32, d);  chk("chk_even_c", {8'd0, d}, 32'h000000);

    // Gradients
    pattern_sel = 3'd1;
    px(0, 0, d);    chk("hg_x0",   {8'd0, d}, 32'h000000);
    px(300, 5, d);  chk("hg_x300", {8'd0, d}, 32'h2C2C2C);
    px(255, 5, d);  chk("hg_x255", {8'd0, d}, 32'hFFFFFF);
    pattern_sel = 3'd2;
    px(0, 0, d);    chk("vg_y0",   {8'd0, d}, 32'h000000);
    px(3, 300, d);  chk("vg_y300", {8'd0, d}, 32'h2C2C2C);

    // Reserved selectors fall back to colour bars
    pattern_sel = 3'd6;
    px(0, 0, d);    chk("remap6_px", {8'd0, d}, 32'hFFFFFF);
    chk("remap6_mode", {29'd0, mode_active}, 32'd0);
    pattern_sel = 3'd5;
    px(0, 0, d);
    chk("mode5", {29'd0, mode_active}, 32'd5);
    pattern_sel = 3'd7;
    px(0, 0, d);
    chk("remap7_mode", {29'd0, mode_active}, 32'd0);

    // Moving bar: scroll 0 -> 300 -> 600 -> 180
    pattern_sel = 3'd5;
    scroll_step = 11'd300;
    px(0, 0, d);    chk("mv1_fs_old", {8'd0, d}, 32'hFFFFFF);
    px(299, 0, d);  chk("mv1_x299", {8'd0, d}, 32'h000000);
    px(300, 0, d);  chk("mv1_x300", {8'd0, d}, 32'hFFFFFF);
    px(331, 0, d);  chk("mv1_x331", {8'd0, d}, 32'hFFFFFF);
    px(332, 0, d);  chk("mv1_x332", {8'd0, d}, 32'h000000);
    px(0, 0, d);    chk("mv2_fs_old", {8'd0, d}, 32'h000000);
    px(599, 0, d);  chk("mv2_x599", {8'd0, d}, 32'h000000);
    px(600, 0, d);  chk("mv2_x600", {8'd0, d}, 32'hFFFFFF);
    px(0, 0, d);    chk("mv3_fs_old", {8'd0, d}, 32'h000000);
    px(179, 0, d);  chk("mv3_x179", {8'd0, d}, 32'h000000);
    px(180, 0, d);  chk("mv3_x180", {8'd0, d}, 32'hFFFFFF);
    px(211, 0, d);  chk("mv3_x211", {8'd0, d}, 32'hFFFFFF);
    px(212, 0, d);  chk("mv3_x212", {8'd0, d}, 32'h000000);
    scroll_step = 11'd0;
    px(0, 0, d);
    px(180, 0, d);  chk("mv4_x180", {8'd0, d}, 32'hFFFFFF);
    chk("mv_fcnt", {16'd0, frame_cnt}, {16'd0, exp_fc});

    // Frame counter wrap
    while (exp_fc != 16'hFFFF) fs_fast();
    #1;
    chk("fcnt_max", {16'd0, frame_cnt}, 32'h0000FFFF);
    px(0, 0, d);
    chk("fcnt_wrap", {16'd0, frame_cnt}, 32'h00000000);

    // Reset asserted mid-frame while requesting
    px(1, 0, d);
    @(negedge clk);
    pif.rgb_data_req = 1'b1;
    pif.pixel_xpos   = 11'd2;
    pif.pixel_ypos   = 11'd0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_valid", {31'd0, pif.pixel_valid}, 32'd0);
    chk("mrst_data",  {8'd0, pif.pixel_data}, 32'd0);
    chk("mrst_fcnt",  {16'd0, frame_cnt}, 32'd0);
    chk("mrst_mode",  {29'd0, mode_active}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pif.rgb_data_req = 1'b0;
    exp_fc = 16'd0;
    px(0, 0, d);    chk("post_rst_px", {8'd0, d}, 32'hFFFFFF);
    chk("post_rst_fcnt", {16'd0, frame_cnt}, {16'd0, exp_fc});
    chk("post_rst_mode", {29'd0, mode_active}, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
